// File: rtl/redirect_remap_arbiter_if.sv
// Bundle of redirect request inputs, config handshake and remap table outputs
// seen by redirect_remap_arbiter. Parameters must match the arbiter instance.
// Latency: none (wires only). Backpressure: cfg_req/cfg_ack handshake is carried here.
//   master : the arbiter side (consumes redirect levels and cfg_ack_i, drives the rest)
//   slave  : the environment side (redirect detect + crossbar remap logic)
interface redirect_remap_arbiter_if #(
  parameter int N_TARG_PORT = 7,
  parameter int LOG_N_INIT  = 2
);
  localparam int N_INIT = 2 ** LOG_N_INIT;

  // per-port redirect requests from the decode stage
  logic [N_TARG_PORT-1:0]            redirect_valid_i;
  logic [N_TARG_PORT*LOG_N_INIT-1:0] source_i;
  logic [N_TARG_PORT*LOG_N_INIT-1:0] target_i;

  // config handshake towards the crossbar remap logic
  logic                  cfg_req_o;
  logic                  cfg_en_o;
  logic [LOG_N_INIT-1:0] cfg_src_o;
  logic [LOG_N_INIT-1:0] cfg_tgt_o;
  logic                  cfg_ack_i;

  // committed remap table and status
  logic [N_INIT-1:0]            remap_en_o;
  logic [N_INIT*LOG_N_INIT-1:0] remap_tgt_o;
  logic                         busy_o;
  logic                         err_self_o;
  logic                         err_timeout_o;

  modport master (
    input  redirect_valid_i, source_i, target_i, cfg_ack_i,
    output cfg_req_o, cfg_en_o, cfg_src_o, cfg_tgt_o,
    output remap_en_o, remap_tgt_o, busy_o, err_self_o, err_timeout_o
  );

  modport slave (
    output redirect_valid_i, source_i, target_i, cfg_ack_i,
    input  cfg_req_o, cfg_en_o, cfg_src_o, cfg_tgt_o,
    input  remap_en_o, remap_tgt_o, busy_o, err_self_o, err_timeout_o
  );
endinterface

// File: rtl/redirect_remap_arbiter.sv
// Turns per-port redirect_valid edges into apply/release ops, round-robins them one at a
// time over a req/ack config handshake, and commits acknowledged ops to a remap table.
// Latency: edge -> pending 1 cycle, pending -> cfg_req_o 1 cycle; ack -> table 1 cycle.
// Backpressure: cfg_req_o held until cfg_ack_i or TIMEOUT; ops stay pending meanwhile.
// Ports: clk, rst (sync active-high), bus (redirect_remap_arbiter_if.master).
module redirect_remap_arbiter #(
  parameter int N_TARG_PORT = 7,
  parameter int LOG_N_INIT  = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  redirect_remap_arbiter_if.master        bus
);
  localparam int N_INIT = 2 ** LOG_N_INIT;
  localparam int PW     = (N_TARG_PORT > 1) ? $clog2(N_TARG_PORT) : 1;
  localparam int CW     = $clog2(TIMEOUT);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  state_t state_q, state_d;

  // per-port edge tracking and pending op
  logic [N_TARG_PORT-1:0]                 prev_valid_q, prev_valid_d;
  logic [N_TARG_PORT-1:0]                 pend_q, pend_d;
  logic [N_TARG_PORT-1:0]                 op_apply_q, op_apply_d;
  logic [N_TARG_PORT-1:0][LOG_N_INIT-1:0] op_src_q, op_src_d;
  logic [N_TARG_PORT-1:0][LOG_N_INIT-1:0] op_tgt_q, op_tgt_d;

  logic [PW-1:0] rr_q, rr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // op currently being configured
  logic                  cfg_en_q, cfg_en_d;
  logic [LOG_N_INIT-1:0] cfg_src_q, cfg_src_d;
  logic [LOG_N_INIT-1:0] cfg_tgt_q, cfg_tgt_d;

  // committed table
  logic [N_INIT-1:0]                 remap_en_q, remap_en_d;
  logic [N_INIT-1:0][LOG_N_INIT-1:0] remap_tgt_q, remap_tgt_d;

  logic err_self_q, err_self_d;
  logic err_timeout_q, err_timeout_d;

  logic [N_TARG_PORT-1:0] rise;
  logic [N_TARG_PORT-1:0] fall;

  logic          gnt_found;
  logic [PW-1:0] gnt_idx;
  logic [PW-1:0] cand;

  always_comb begin
    rise = bus.redirect_valid_i & ~prev_valid_q;
    fall = ~bus.redirect_valid_i & prev_valid_q;
  end

  // Round-robin search: rr_q+1 first, rr_q (last winner) last.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N_TARG_PORT; k++) begin
      cand = PW'((int'(rr_q) + k) % N_TARG_PORT);
      if (!gnt_found && pend_q[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    prev_valid_d  = bus.redirect_valid_i;
    pend_d        = pend_q;
    op_apply_d    = op_apply_q;
    op_src_d      = op_src_q;
    op_tgt_d      = op_tgt_q;
    rr_d          = rr_q;
    cnt_d         = cnt_q;
    cfg_en_d      = cfg_en_q;
    cfg_src_d     = cfg_src_q;
    cfg_tgt_d     = cfg_tgt_q;
    remap_en_d    = remap_en_q;
    remap_tgt_d   = remap_tgt_q;
    err_self_d    = 1'b0;
    err_timeout_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (gnt_found) begin
          rr_d            = gnt_idx;
          pend_d[gnt_idx] = 1'b0;
          cnt_d           = '0;
          cfg_en_d        = op_apply_q[gnt_idx];
          cfg_src_d       = op_src_q[gnt_idx];
          cfg_tgt_d       = op_apply_q[gnt_idx] ? op_tgt_q[gnt_idx] : '0;
          // A redirect onto itself is meaningless; drop it without touching the xbar.
          if (op_apply_q[gnt_idx] && (op_src_q[gnt_idx] == op_tgt_q[gnt_idx])) begin
            err_self_d = 1'b1;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        // ack takes priority over a timeout landing in the same cycle
        if (bus.cfg_ack_i) begin
          remap_en_d[cfg_src_q]  = cfg_en_q;
          remap_tgt_d[cfg_src_q] = cfg_tgt_q;
          state_d                = ST_IDLE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_timeout_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Edge capture runs after the grant clear so an edge on the granted port re-arms it.
    // A newer edge simply overwrites the pending op; src/tgt are latched on rise only.
    for (int i = 0; i < N_TARG_PORT; i++) begin
      if (rise[i]) begin
        pend_d[i]     = 1'b1;
        op_apply_d[i] = 1'b1;
        op_src_d[i]   = bus.source_i[i*LOG_N_INIT +: LOG_N_INIT];
        op_tgt_d[i]   = bus.target_i[i*LOG_N_INIT +: LOG_N_INIT];
      end else if (fall[i]) begin
        pend_d[i]     = 1'b1;
        op_apply_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      prev_valid_q  <= '0;
      pend_q        <= '0;
      op_apply_q    <= '0;
      op_src_q      <= '0;
      op_tgt_q      <= '0;
      rr_q          <= PW'(N_TARG_PORT - 1);
      cnt_q         <= '0;
      cfg_en_q      <= 1'b0;
      cfg_src_q     <= '0;
      cfg_tgt_q     <= '0;
      remap_en_q    <= '0;
      remap_tgt_q   <= '0;
      err_self_q    <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_valid_q  <= prev_valid_d;
      pend_q        <= pend_d;
      op_apply_q    <= op_apply_d;
      op_src_q      <= op_src_d;
      op_tgt_q      <= op_tgt_d;
      rr_q          <= rr_d;
      cnt_q         <= cnt_d;
      cfg_en_q      <= cfg_en_d;
      cfg_src_q     <= cfg_src_d;
      cfg_tgt_q     <= cfg_tgt_d;
      remap_en_q    <= remap_en_d;
      remap_tgt_q   <= remap_tgt_d;
      err_self_q    <= err_self_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign bus.cfg_req_o     = (state_q == ST_REQ);
  assign bus.cfg_en_o      = cfg_en_q;
  assign bus.cfg_src_o     = cfg_src_q;
  assign bus.cfg_tgt_o     = cfg_tgt_q;
  assign bus.remap_en_o    = remap_en_q;
  assign bus.remap_tgt_o   = remap_tgt_q;
  assign bus.busy_o        = (state_q != ST_IDLE) || (|pend_q);
  assign bus.err_self_o    = err_self_q;
  assign bus.err_timeout_o = err_timeout_q;

endmodule

// File: tb/tb_redirect_remap_arbiter.sv
// Bench for redirect_remap_arbiter: directed scenarios plus a randomized run checked
// against a cycle-level behavioural model of the redirect/op/table rules.
module tb_redirect_remap_arbiter;
  localparam int N  = 7;
  localparam int L  = 2;
  localparam int NI = 4;
  localparam int TO = 8;
  localparam int NL = N * L;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passes = 0;

  redirect_remap_arbiter_if #(.N_TARG_PORT(N), .LOG_N_INIT(L)) bus();

  redirect_remap_arbiter #(.N_TARG_PORT(N), .LOG_N_INIT(L), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit m_prev [N];
  bit m_pend [N];
  bit m_apply[N];
  int m_src  [N];
  int m_tgt  [N];
  int m_rr;
  bit m_inflight;
  int m_waited;
  int m_cfg_en, m_cfg_src, m_cfg_tgt;
  int m_tab_en [NI];
  int m_tab_tgt[NI];
  bit m_err_self, m_err_to;

  task automatic model_step();
    bit v;
    bit found;
    int g;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_prev[i] = 0; m_pend[i] = 0; m_apply[i] = 0; m_src[i] = 0; m_tgt[i] = 0;
      end
      for (int s = 0; s < NI; s++) begin m_tab_en[s] = 0; m_tab_tgt[s] = 0; end
      m_rr = N - 1; m_inflight = 0; m_waited = 0;
      m_cfg_en = 0; m_cfg_src = 0; m_cfg_tgt = 0;
      m_err_self = 0; m_err_to = 0;
    end else begin
      m_err_self = 0;
      m_err_to   = 0;
      if (m_inflight) begin
        if (bus.cfg_ack_i) begin
          m_tab_en[m_cfg_src]  = m_cfg_en;
          m_tab_tgt[m_cfg_src] = m_cfg_tgt;
          m_inflight = 0;
        end else if (m_waited == TO - 1) begin
          m_err_to   = 1;
          m_inflight = 0;
        end else begin
          m_waited++;
        end
      end else begin
        found = 0;
        g = 0;
        for (int k = 1; k <= N; k++)
          if (!found && m_pend[(m_rr + k) % N]) begin found = 1; g = (m_rr + k) % N; end
        if (found) begin
          m_pend[g] = 0;
          m_rr      = g;
          m_cfg_en  = m_apply[g];
          m_cfg_src = m_src[g];
          m_cfg_tgt = m_apply[g] ? m_tgt[g] : 0;
          if (m_apply[g] && m_src[g] == m_tgt[g]) m_err_self = 1;
          else begin m_inflight = 1; m_waited = 0; end
        end
      end
      for (int i = 0; i < N; i++) begin
        v = bus.redirect_valid_i[i];
        if (v && !m_prev[i]) begin
          m_pend[i] = 1; m_apply[i] = 1;
          m_src[i] = int'(bus.source_i[i*L +: L]);
          m_tgt[i] = int'(bus.target_i[i*L +: L]);
        end else if (!v && m_prev[i]) begin
          m_pend[i] = 1; m_apply[i] = 0;
        end
        m_prev[i] = v;
      end
    end
  endtask

  function automatic bit m_busy();
    bit b;
    b = m_inflight;
    for (int i = 0; i < N; i++) b = b | m_pend[i];
    return b;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_port(input int p, input bit v, input int s, input int t);
    bus.redirect_valid_i[p] = v;
    bus.source_i[p*L +: L]  = L'(s);
    bus.target_i[p*L +: L]  = L'(t);
  endtask

  task automatic ack_pulse();
    bus.cfg_ack_i = 1'b1;
    tick();
    bus.cfg_ack_i = 1'b0;
  endtask

  task automatic wait_req(input int budget, output bit ok);
    ok = bus.cfg_req_o;
    for (int n = 0; n < budget && !ok; n++) begin
      tick();
      ok = bus.cfg_req_o;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.redirect_valid_i = '0;
    bus.source_i = '0;
    bus.target_i = '0;
    bus.cfg_ack_i = 1'b0;
    tick(); tick();
    checks++; if (bus.cfg_req_o !== 1'b0) $display("FAIL reset_req got=%b exp=0", bus.cfg_req_o); else passes++;
    checks++; if (bus.busy_o !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy_o); else passes++;
    checks++; if (bus.remap_en_o !== 4'b0 || bus.remap_tgt_o !== 8'h00)
      $display("FAIL reset_table got en=%b tgt=%h exp 0/00", bus.remap_en_o, bus.remap_tgt_o); else passes++;
    checks++; if ({bus.cfg_en_o, bus.cfg_src_o, bus.cfg_tgt_o, bus.err_self_o, bus.err_timeout_o} !== 7'b0)
      $display("FAIL reset_cfg_err got en=%b src=%0d tgt=%0d es=%b et=%b exp all 0",
               bus.cfg_en_o, bus.cfg_src_o, bus.cfg_tgt_o, bus.err_self_o, bus.err_timeout_o); else passes++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_apply_release();
    set_port(2, 1, 1, 3);
    tick();
    checks++; if (bus.busy_o !== 1'b1 || bus.cfg_req_o !== 1'b0)
      $display("FAIL ar_pend got busy=%b req=%b exp 1/0", bus.busy_o, bus.cfg_req_o); else passes++;
    tick();
    checks++; if ({bus.cfg_req_o, bus.cfg_en_o, bus.cfg_src_o, bus.cfg_tgt_o} !== {1'b1, 1'b1, 2'd1, 2'd3})
      $display("FAIL ar_apply_cfg got req=%b en=%b src=%0d tgt=%0d exp 1/1/1/3",
               bus.cfg_req_o, bus.cfg_en_o, bus.cfg_src_o, bus.cfg_tgt_o); else passes++;
    tick(); tick();
    checks++; if (bus.cfg_req_o !== 1'b1 || bus.remap_en_o[1] !== 1'b0)
      $display("FAIL ar_hold got req=%b en1=%b exp 1/0", bus.cfg_req_o, bus.remap_en_o[1]); else passes++;
    ack_pulse();
    checks++; if (bus.cfg_req_o !== 1'b0 || bus.remap_en_o[1] !== 1'b1 || bus.remap_tgt_o[3:2] !== 2'd3)
      $display("FAIL ar_commit got req=%b en1=%b tgt1=%0d exp 0/1/3",
               bus.cfg_req_o, bus.remap_en_o[1], bus.remap_tgt_o[3:2]); else passes++;
    set_port(2, 0, 0, 0);
    tick(); tick();
    checks++; if ({bus.cfg_req_o, bus.cfg_en_o, bus.cfg_src_o, bus.cfg_tgt_o} !== {1'b1, 1'b0, 2'd1, 2'd0})
      $display("FAIL ar_release_cfg got req=%b en=%b src=%0d tgt=%0d exp 1/0/1/0",
               bus.cfg_req_o, bus.cfg_en_o, bus.cfg_src_o, bus.cfg_tgt_o); else passes++;
    ack_pulse();
    checks++; if (bus.remap_en_o[1] !== 1'b0 || bus.remap_tgt_o[3:2] !== 2'd0)
      $display("FAIL ar_release_commit got en1=%b tgt1=%0d exp 0/0", bus.remap_en_o[1], bus.remap_tgt_o[3:2]); else passes++;
  endtask

  task automatic test_rr_order();
    bit ok;
    int got[3];
    int exp_src[3];
    exp_src[0] = 3; exp_src[1] = 0; exp_src[2] = 2;
    // park the pointer on port 3 with an apply/release pair
    set_port(3, 1, 0, 1);
    wait_req(10, ok); ack_pulse();
    set_port(3, 0, 0, 0);
    wait_req(10, ok);
    checks++; if (ok !== 1'b1) $display("FAIL rr_setup got req=%b exp 1", ok); else passes++;
    ack_pulse();
    set_port(0, 1, 0, 2);
    set_port(3, 1, 2, 1);
    set_port(5, 1, 3, 0);
    for (int j = 0; j < 3; j++) begin
      wait_req(12, ok);
      got[j] = int'(bus.cfg_src_o);
      checks++; if (ok !== 1'b1) $display("FAIL rr_req%0d timed out", j); else passes++;
      tick();
      ack_pulse();
      checks++; if (bus.cfg_req_o !== 1'b0) $display("FAIL rr_overlap%0d got req=%b exp 0", j, bus.cfg_req_o); else passes++;
    end
    for (int j = 0; j < 3; j++) begin
      checks++; if (got[j] !== exp_src[j]) $display("FAIL rr_order%0d got src=%0d exp %0d", j, got[j], exp_src[j]); else passes++;
    end
    checks++; if (bus.remap_en_o !== 4'b1101 || bus.remap_tgt_o !== 8'h12)
      $display("FAIL rr_table got en=%b tgt=%h exp 1101/12", bus.remap_en_o, bus.remap_tgt_o); else passes++;
  endtask

  task automatic test_self_err();
    int errs = 0;
    int reqs = 0;
    set_port(4, 1, 2, 2);
    repeat (6) begin
      tick();
      errs += int'(bus.err_self_o);
      reqs += int'(bus.cfg_req_o);
    end
    checks++; if (errs !== 1) $display("FAIL self_err_pulses got=%0d exp 1", errs); else passes++;
    checks++; if (reqs !== 0) $display("FAIL self_err_reqs got=%0d exp 0", reqs); else passes++;
    checks++; if (bus.remap_en_o !== 4'b1101 || bus.remap_tgt_o !== 8'h12 || bus.busy_o !== 1'b0)
      $display("FAIL self_err_table got en=%b tgt=%h busy=%b exp 1101/12/0",
               bus.remap_en_o, bus.remap_tgt_o, bus.busy_o); else passes++;
  endtask

  task automatic test_timeout();
    int reqs = 0;
    int tos = 0;
    set_port(6, 1, 0, 3);
    repeat (20) begin
      tick();
      reqs += int'(bus.cfg_req_o);
      tos  += int'(bus.err_timeout_o);
    end
    checks++; if (reqs !== TO) $display("FAIL timeout_req_cycles got=%0d exp %0d", reqs, TO); else passes++;
    checks++; if (tos !== 1) $display("FAIL timeout_pulses got=%0d exp 1", tos); else passes++;
    checks++; if (bus.remap_en_o !== 4'b1101 || bus.remap_tgt_o !== 8'h12 || bus.busy_o !== 1'b0)
      $display("FAIL timeout_table got en=%b tgt=%h busy=%b exp 1101/12/0",
               bus.remap_en_o, bus.remap_tgt_o, bus.busy_o); else passes++;
  endtask

  task automatic test_latest_wins();
    bit ok;
    int reqs = 0;
    set_port(6, 0, 0, 0);
    wait_req(10, ok);
    set_port(1, 1, 1, 2);
    tick();
    set_port(1, 0, 0, 0);
    tick();
    ack_pulse();
    wait_req(8, ok);
    checks++; if (ok !== 1'b1) $display("FAIL latest_req timed out"); else passes++;
    checks++; if ({bus.cfg_en_o, bus.cfg_src_o, bus.cfg_tgt_o} !== {1'b0, 2'd1, 2'd0})
      $display("FAIL latest_cfg got en=%b src=%0d tgt=%0d exp 0/1/0",
               bus.cfg_en_o, bus.cfg_src_o, bus.cfg_tgt_o); else passes++;
    ack_pulse();
    repeat (8) begin
      tick();
      reqs += int'(bus.cfg_req_o);
    end
    checks++; if (reqs !== 0) $display("FAIL latest_extra_reqs got=%0d exp 0", reqs); else passes++;
    checks++; if (bus.remap_en_o !== 4'b1100 || bus.busy_o !== 1'b0)
      $display("FAIL latest_table got en=%b busy=%b exp 1100/0", bus.remap_en_o, bus.busy_o); else passes++;
  endtask

  task automatic test_reset_mid_req();
    bit ok;
    set_port(0, 0, 0, 0);
    wait_req(10, ok);
    checks++; if (ok !== 1'b1) $display("FAIL rstmid_req timed out"); else passes++;
    rst = 1'b1;
    bus.redirect_valid_i = '0;
    tick();
    checks++; if (bus.cfg_req_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.remap_en_o !== 4'b0)
      $display("FAIL rstmid_state got req=%b busy=%b en=%b exp 0/0/0000",
               bus.cfg_req_o, bus.busy_o, bus.remap_en_o); else passes++;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [NI-1:0]   exp_en;
    logic [NI*L-1:0] exp_tgt;
    for (int c = 0; c < 800; c++) begin
      for (int p = 0; p < N; p++)
        if ($urandom_range(0, 9) == 0) bus.redirect_valid_i[p] = ~bus.redirect_valid_i[p];
      bus.source_i  = NL'($urandom);
      bus.target_i  = NL'($urandom);
      bus.cfg_ack_i = ($urandom_range(0, 2) == 0);
      tick();
      for (int s = 0; s < NI; s++) begin
        exp_en[s] = m_tab_en[s][0];
        exp_tgt[s*L +: L] = L'(m_tab_tgt[s]);
      end
      checks++; if (bus.cfg_req_o !== m_inflight)
        $display("FAIL rnd_req c=%0d got=%b exp=%b", c, bus.cfg_req_o, m_inflight); else passes++;
      checks++; if (bus.busy_o !== m_busy())
        $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, bus.busy_o, m_busy()); else passes++;
      checks++; if (bus.err_self_o !== m_err_self || bus.err_timeout_o !== m_err_to)
        $display("FAIL rnd_err c=%0d got=%b%b exp=%b%b", c, bus.err_self_o, bus.err_timeout_o, m_err_self, m_err_to); else passes++;
      checks++; if (bus.remap_en_o !== exp_en || bus.remap_tgt_o !== exp_tgt)
        $display("FAIL rnd_table c=%0d got=%b/%h exp=%b/%h", c, bus.remap_en_o, bus.remap_tgt_o, exp_en, exp_tgt); else passes++;
      if (m_inflight) begin
        checks++; if (int'(bus.cfg_en_o) !== m_cfg_en || int'(bus.cfg_src_o) !== m_cfg_src || int'(bus.cfg_tgt_o) !== m_cfg_tgt)
          $display("FAIL rnd_cfg c=%0d got=%b/%0d/%0d exp=%0d/%0d/%0d", c, bus.cfg_en_o, bus.cfg_src_o,
                   bus.cfg_tgt_o, m_cfg_en, m_cfg_src, m_cfg_tgt); else passes++;
      end
    end
    bus.cfg_ack_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_apply_release();
    test_rr_order();
    test_self_err();
    test_timeout();
    test_latest_wins();
    test_reset_mid_req();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired after %0d checks", checks);
    $fatal(1);
  end

endmodule
